atomic_mem_ctrl: RTL
====================

ATOMIC_MEM_CTRL -- requirements
Module: atomic_mem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (32 or 64).
REQ-002 SHALL have parameter N_IDS, default 2, number of harts holding LR reservations; ID_W = max(1, clog2(N_IDS)).
REQ-003 i_clk  in  1  clock; reset i_rst, synchronous, active-low.
REQ-004 i_rst  in  1  synchronous active-low reset.
REQ-005 i_bus_en  in  1  CPU request valid.
REQ-006 i_wr_en, i_atomic  in  1 each  store / atomic qualifiers.
REQ-007 i_addr, i_wr_data  in  XLEN each  request address / store data or AMO operand.
REQ-008 i_byte_en  in  XLEN/8  byte strobes.
REQ-009 i_id  in  ID_W  requesting hart.
REQ-010 i_operation  in  7  AMO funct7; [6:2] = funct5.
REQ-011 o_ack  out  1; o_rd_data  out  XLEN  CPU response.
REQ-012 o_bus_en, o_wr_en  out  1; o_addr, o_wr_data  out  XLEN; o_byte_en  out  XLEN/8  memory request.
REQ-013 i_ack  in  1; i_rd_data  in  XLEN  memory response.
REQ-014 o_busy  out  1  high whenever state != IDLE.

Function
REQ-015 All outputs SHALL be registered; request fields SHALL be captured when accepted in IDLE.
REQ-016 States: IDLE, ACCESS, AMO_RD, AMO_EX, AMO_WR, RESP.
REQ-017 IDLE: i_bus_en with i_atomic=0 or LR -> ACCESS; SC -> ACCESS if grant else RESP; other atomic -> AMO_RD; i_bus_en ignored outside IDLE.
REQ-018 o_bus_en SHALL be high from the cycle after acceptance until the cycle after i_ack is sampled high; o_wr_en held with it.
REQ-019 ACCESS/AMO_WR on i_ack -> IDLE with o_ack pulse exactly one cycle; AMO_RD on i_ack -> AMO_EX, capturing i_rd_data as old value.
REQ-020 AMO_EX SHALL last one cycle, compute result, then AMO_WR with o_wr_en=1, same address/strobes.
REQ-021 funct5: ADD 00000, SWAP 00001, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100; MIN/MAX signed; unknown funct5 writes back old value unchanged.
REQ-022 AMO o_rd_data SHALL be the old memory value; plain load returns i_rd_data; store returns 0.
REQ-023 Plain access latency: o_ack = 1 cycle after i_ack sample; AMO: minimum 5 cycles accept-to-ack with zero-wait memory.
REQ-024 Reservation table: per-ID valid bit plus addr[XLEN-1:2]; LR sets own entry on its i_ack.
REQ-025 SC grant = own entry valid and word address match; success performs write, returns 0; failure: no memory access, RESP one cycle, o_ack with o_rd_data=1.
REQ-026 Every SC SHALL clear its own entry; every completed write (store, AMO, successful SC) SHALL clear all IDs' entries matching that word.
REQ-027 When o_ack is low, o_rd_data SHALL hold its last value.

Reset
REQ-028 Reset SHALL force state IDLE, all outputs 0, all reservations invalid, abandoning any in-flight transaction without ack.
REQ-029 Reset asserted on the same cycle as i_bus_en SHALL take priority; request dropped.

Configuration
REQ-030 With ATOMIC_LRSC_EN defined: reservation table and REQ-024..026 active.
REQ-031 Without ATOMIC_LRSC_EN: no table; LR behaves as plain load; SC always fails (no write, o_rd_data=1); AMOs unaffected.

Structure
REQ-032 Package atomic_pkg SHALL hold funct5 constants and state encodings.
REQ-033 Combinational sub-module amo_alu (funct5, old, operand -> result) SHALL be instantiated once.

Verification
REQ-034 Store 0xDEADBEEF to 0x100, zero-wait memory -> o_wr_en=1, o_addr=0x100, o_ack 1 cycle after i_ack, o_rd_data=0.
REQ-035 AMOADD operand 5, memory 0x10 -> write 0x15, o_rd_data=0x10.
REQ-036 AMOMIN operand 0xFFFFFFFF, memory 1 -> write 0xFFFFFFFF; AMOMINU same -> write 1.
REQ-037 ID0 LR 0x200, ID0 SC 0x200 -> write occurs, rd=0; repeat SC -> no write, rd=1.
REQ-038 ID0 LR 0x200, ID1 store 0x200, ID0 SC 0x200 -> fails, rd=1.
REQ-039 Reset during AMO_RD with i_ack pending -> next cycle all outputs 0, no o_ack, following SC fails.

Source files
------------

// File: rtl/atomic_pkg.sv
// Shared encodings for the atomic memory controller: AMO funct5 codes, FSM states,
// request kinds and the ID-width helper.
package atomic_pkg;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    AMO_RD = 3'd2,
    AMO_EX = 3'd3,
    AMO_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_LOAD  = 3'd0,
    K_STORE = 3'd1,
    K_LR    = 3'd2,
    K_SC    = 3'd3,
    K_AMO   = 3'd4
  } kind_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/atomic_mem_ctrl_if.sv
// Bundle of CPU-side request/response and memory-side request/response signals.
// slave = controller view, master = the CPU/memory side that drives the i_* signals.
interface atomic_mem_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int N_IDS = 2
);
  localparam int ID_W = atomic_pkg::id_width(N_IDS);

  // CPU request / response
  logic              i_bus_en;
  logic              i_wr_en;
  logic              i_atomic;
  logic [XLEN-1:0]   i_addr;
  logic [XLEN-1:0]   i_wr_data;
  logic [XLEN/8-1:0] i_byte_en;
  logic [ID_W-1:0]   i_id;
  logic [6:0]        i_operation;
  logic              o_ack;
  logic [XLEN-1:0]   o_rd_data;
  logic              o_busy;

  // Memory request / response
  logic              o_bus_en;
  logic              o_wr_en;
  logic [XLEN-1:0]   o_addr;
  logic [XLEN-1:0]   o_wr_data;
  logic [XLEN/8-1:0] o_byte_en;
  logic              i_ack;
  logic [XLEN-1:0]   i_rd_data;

  modport slave (
    input  i_bus_en, i_wr_en, i_atomic, i_addr, i_wr_data, i_byte_en, i_id, i_operation,
    input  i_ack, i_rd_data,
    output o_ack, o_rd_data, o_busy,
    output o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
  );

  modport master (
    output i_bus_en, i_wr_en, i_atomic, i_addr, i_wr_data, i_byte_en, i_id, i_operation,
    output i_ack, i_rd_data,
    input  o_ack, o_rd_data, o_busy,
    input  o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
  );

endinterface

// File: rtl/amo_alu.sv
// Combinational AMO read-modify-write datapath: new memory value from funct5, old value and operand.
// Unknown funct5 codes write the old value back unchanged.
module amo_alu
  import atomic_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = old_val;
    case (funct5)
      F5_ADD:  result = old_val + operand;
      F5_SWAP: result = operand;
      F5_XOR:  result = old_val ^ operand;
      F5_OR:   result = old_val | operand;
      F5_AND:  result = old_val & operand;
      F5_MIN:  result = ($signed(old_val) < $signed(operand)) ? old_val : operand;
      F5_MAX:  result = ($signed(old_val) > $signed(operand)) ? old_val : operand;
      F5_MINU: result = (old_val < operand) ? old_val : operand;
      F5_MAXU: result = (old_val > operand) ? old_val : operand;
      default: result = old_val;
    endcase
  end

endmodule

// File: rtl/atomic_mem_ctrl.sv
// Atomic memory controller: plain loads/stores, AMO read-modify-write and LR/SC in front of one memory port.
// Build option ATOMIC_LRSC_EN adds the per-hart reservation table; without it LR is a plain load and SC always fails.
module atomic_mem_ctrl
  import atomic_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int N_IDS = 2
) (
  input  logic   i_clk,
  input  logic   i_rst,
  atomic_mem_ctrl_if.slave bus,
  output state_t o_state
);

  localparam int ID_W = id_width(N_IDS);
  localparam int BE_W = XLEN / 8;

  // Handshake: a CPU request is taken only in IDLE on an edge where i_bus_en is high; a memory
  // request completes on the edge where o_bus_en and i_ack are both high; o_ack pulses one cycle.

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [4:0]      f5_q, f5_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            bus_en_q, bus_en_d;
  logic            wr_en_q, wr_en_d;
  logic            ack_q, ack_d;
  logic            busy_q;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [BE_W-1:0] be_q, be_d;

  logic [XLEN-1:0] alu_result;
  logic [4:0]      req_f5;
  logic            sc_grant;
  logic            sc_clear;
  logic            wr_done;
  logic            lr_done;

  assign req_f5 = bus.i_operation[6:2];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      kind_q    <= K_LOAD;
      id_q      <= '0;
      f5_q      <= '0;
      operand_q <= '0;
      old_q     <= '0;
      bus_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      id_q      <= id_d;
      f5_q      <= f5_d;
      operand_q <= operand_d;
      old_q     <= old_d;
      bus_en_q  <= bus_en_d;
      wr_en_q   <= wr_en_d;
      ack_q     <= ack_d;
      busy_q    <= (state_d != IDLE);
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      be_q      <= be_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    id_d      = id_q;
    f5_d      = f5_q;
    operand_d = operand_q;
    old_d     = old_q;
    bus_en_d  = bus_en_q;
    wr_en_d   = wr_en_q;
    ack_d     = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    be_d      = be_q;
    sc_clear  = 1'b0;
    wr_done   = 1'b0;
    lr_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_bus_en) begin
          addr_d    = bus.i_addr;
          be_d      = bus.i_byte_en;
          id_d      = bus.i_id;
          f5_d      = req_f5;
          operand_d = bus.i_wr_data;
          wr_data_d = bus.i_wr_data;
          if (!bus.i_atomic) begin
            kind_d   = bus.i_wr_en ? K_STORE : K_LOAD;
            state_d  = ACCESS;
            bus_en_d = 1'b1;
            wr_en_d  = bus.i_wr_en;
          end else if (req_f5 == F5_LR) begin
            kind_d   = K_LR;
            state_d  = ACCESS;
            bus_en_d = 1'b1;
            wr_en_d  = 1'b0;
          end else if (req_f5 == F5_SC) begin
            kind_d   = K_SC;
            sc_clear = 1'b1;
            if (sc_grant) begin
              state_d  = ACCESS;
              bus_en_d = 1'b1;
              wr_en_d  = 1'b1;
            end else begin
              // Failed SC never touches memory
              state_d = RESP;
            end
          end else begin
            kind_d   = K_AMO;
            state_d  = AMO_RD;
            bus_en_d = 1'b1;
            wr_en_d  = 1'b0;
          end
        end
      end

      ACCESS: begin
        if (bus.i_ack) begin
          state_d  = IDLE;
          bus_en_d = 1'b0;
          wr_en_d  = 1'b0;
          ack_d    = 1'b1;
          wr_done  = wr_en_q;
          lr_done  = (kind_q == K_LR);
          if ((kind_q == K_LOAD) || (kind_q == K_LR)) rd_data_d = bus.i_rd_data;
          else                                        rd_data_d = '0;
        end
      end

      AMO_RD: begin
        if (bus.i_ack) begin
          old_d    = bus.i_rd_data;
          state_d  = AMO_EX;
          bus_en_d = 1'b0;
        end
      end

      AMO_EX: begin
        wr_data_d = alu_result;
        bus_en_d  = 1'b1;
        wr_en_d   = 1'b1;
        state_d   = AMO_WR;
      end

      AMO_WR: begin
        if (bus.i_ack) begin
          state_d   = IDLE;
          bus_en_d  = 1'b0;
          wr_en_d   = 1'b0;
          ack_d     = 1'b1;
          wr_done   = 1'b1;
          rd_data_d = old_q;
        end
      end

      RESP: begin
        state_d   = IDLE;
        ack_d     = 1'b1;
        rd_data_d = {{(XLEN-1){1'b0}}, 1'b1};
      end

      default: begin
        state_d  = IDLE;
        bus_en_d = 1'b0;
        wr_en_d  = 1'b0;
      end
    endcase
  end

  amo_alu #(.XLEN(XLEN)) u_amo_alu (
    .funct5  (f5_q),
    .old_val (old_q),
    .operand (operand_q),
    .result  (alu_result)
  );

`ifdef ATOMIC_LRSC_EN
  logic [N_IDS-1:0] res_valid_q;
  logic [XLEN-3:0]  res_addr_q [N_IDS];

  assign sc_grant = res_valid_q[bus.i_id] && (res_addr_q[bus.i_id] == bus.i_addr[XLEN-1:2]);

  // Write snoop runs first so an LR completing later re-arms its own entry cleanly
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      res_valid_q <= '0;
      for (int i = 0; i < N_IDS; i++) res_addr_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_IDS; i++) begin
        if (wr_done && (res_addr_q[i] == addr_q[XLEN-1:2])) res_valid_q[i] <= 1'b0;
      end
      if (sc_clear) res_valid_q[bus.i_id] <= 1'b0;
      if (lr_done) begin
        res_valid_q[id_q] <= 1'b1;
        res_addr_q[id_q]  <= addr_q[XLEN-1:2];
      end
    end
  end
`else
  logic unused_lrsc;
  assign sc_grant    = 1'b0;
  assign unused_lrsc = ^{sc_clear, wr_done, lr_done, id_q};
`endif

  logic unused_op;
  assign unused_op = ^bus.i_operation[1:0];

  assign bus.o_bus_en  = bus_en_q;
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_addr    = addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_byte_en = be_q;
  assign bus.o_ack     = ack_q;
  assign bus.o_rd_data = rd_data_q;
  assign bus.o_busy    = busy_q;
  assign o_state       = state_q;

endmodule
